// File: rtl/axi_lite_mem_slv.sv
// AXI4-Lite byte-strobed word memory responder for one crossbar master leg.
// Independent write (AW+W -> B) and read (AR -> R) FSMs, one outstanding beat per channel.
module axi_lite_mem_slv #(
    parameter int unsigned          AddrWidth = 32,
    parameter int unsigned          DataWidth = 64,
    parameter int unsigned          NumWords  = 256,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0,
    parameter bit                   PrivOnly  = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [AddrWidth-1:0]   aw_addr_i,
    input  logic [2:0]             aw_prot_i,
    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [DataWidth-1:0]   w_data_i,
    input  logic [DataWidth/8-1:0] w_strb_i,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    output logic [1:0]             b_resp_o,
    output logic                   b_valid_o,
    input  logic                   b_ready_i,
    input  logic [AddrWidth-1:0]   ar_addr_i,
    input  logic [2:0]             ar_prot_i,
    input  logic                   ar_valid_i,
    output logic                   ar_ready_o,
    output logic [DataWidth-1:0]   r_data_o,
    output logic [1:0]             r_resp_o,
    output logic                   r_valid_o,
    input  logic                   r_ready_i
);
    localparam int unsigned        StrbWidth = DataWidth / 8;
    localparam int unsigned        OffLsb    = $clog2(StrbWidth);
    localparam int unsigned        IdxWidth  = $clog2(NumWords);
    localparam logic [AddrWidth:0] MemBytes  = (AddrWidth+1)'(NumWords * StrbWidth);
    localparam logic [1:0]         RespOkay  = 2'b00;
    localparam logic [1:0]         RespSlv   = 2'b10;
    localparam logic [1:0]         RespDec   = 2'b11;

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_RESP} r_state_e;

    logic [DataWidth-1:0] r_mem [NumWords];

    // Held high through reset and the first cycle after it so every ready starts low.
    logic r_init;
    always_ff @(posedge clk_i) begin
        r_init <= rst_i;
    end

    // ---------------- write channel ----------------
    w_state_e              r_wstate, w_wstate_nxt;
    logic                  r_aw_cap, r_w_cap;
    logic [AddrWidth-1:0]  r_aw_addr;
    logic                  r_aw_prot0;
    logic [DataWidth-1:0]  r_w_data;
    logic [StrbWidth-1:0]  r_w_strb;
    logic [1:0]            r_b_resp;
    logic                  w_commit, w_aw_hs, w_w_hs;
    logic [AddrWidth-1:0]  w_aw_off;
    logic [IdxWidth-1:0]   w_widx;
    logic [1:0]            w_wresp;

    assign w_aw_off = r_aw_addr - BaseAddr;
    assign w_widx   = w_aw_off[OffLsb +: IdxWidth];
    assign w_wresp  = ({1'b0, w_aw_off} >= MemBytes) ? RespDec :
                      (PrivOnly && !r_aw_prot0)      ? RespSlv : RespOkay;
    assign w_aw_hs  = aw_valid_i && aw_ready_o;
    assign w_w_hs   = w_valid_i && w_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_wstate <= W_IDLE;
        else       r_wstate <= w_wstate_nxt;
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        aw_ready_o   = 1'b0;
        w_ready_o    = 1'b0;
        w_commit     = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                aw_ready_o = !r_init && !r_aw_cap;
                w_ready_o  = !r_init && !r_w_cap;
                if (r_aw_cap && r_w_cap) begin
                    w_commit     = 1'b1;
                    w_wstate_nxt = W_RESP;
                end
            end
            W_RESP: if (b_ready_i) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_aw_cap   <= 1'b0;
            r_w_cap    <= 1'b0;
            r_aw_addr  <= '0;
            r_aw_prot0 <= 1'b0;
            r_w_data   <= '0;
            r_w_strb   <= '0;
            r_b_resp   <= RespOkay;
        end else if (w_commit) begin
            r_aw_cap <= 1'b0;
            r_w_cap  <= 1'b0;
            r_b_resp <= w_wresp;
        end else begin
            if (w_aw_hs) begin
                r_aw_cap   <= 1'b1;
                r_aw_addr  <= aw_addr_i;
                r_aw_prot0 <= aw_prot_i[0];
            end
            if (w_w_hs) begin
                r_w_cap  <= 1'b1;
                r_w_data <= w_data_i;
                r_w_strb <= w_strb_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumWords; i++) r_mem[i] <= '0;
        end else if (w_commit && w_wresp == RespOkay) begin
            for (int k = 0; k < StrbWidth; k++)
                if (r_w_strb[k]) r_mem[w_widx][8*k +: 8] <= r_w_data[8*k +: 8];
        end
    end

    assign b_valid_o = (r_wstate == W_RESP);
    assign b_resp_o  = r_b_resp;

    // ---------------- read channel ----------------
    r_state_e              r_rstate, w_rstate_nxt;
    logic [DataWidth-1:0]  r_rdata;
    logic [1:0]            r_rresp;
    logic                  w_ar_hs;
    logic [AddrWidth-1:0]  w_ar_off;
    logic [IdxWidth-1:0]   w_ridx;
    logic [1:0]            w_rresp;

    assign w_ar_off = ar_addr_i - BaseAddr;
    assign w_ridx   = w_ar_off[OffLsb +: IdxWidth];
    assign w_rresp  = ({1'b0, w_ar_off} >= MemBytes) ? RespDec :
                      (PrivOnly && !ar_prot_i[0])    ? RespSlv : RespOkay;
    assign w_ar_hs  = ar_valid_i && ar_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_rstate <= R_IDLE;
        else       r_rstate <= w_rstate_nxt;
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        ar_ready_o   = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                ar_ready_o = !r_init;
                if (ar_valid_i && !r_init) w_rstate_nxt = R_RESP;
            end
            R_RESP: if (r_ready_i) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Sampling the array with <= gives pre-write data when a commit lands on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata <= '0;
            r_rresp <= RespOkay;
        end else if (w_ar_hs) begin
            r_rdata <= (w_rresp == RespOkay) ? r_mem[w_ridx] : '0;
            r_rresp <= w_rresp;
        end
    end

    assign r_valid_o = (r_rstate == R_RESP);
    assign r_data_o  = r_rdata;
    assign r_resp_o  = r_rresp;

    logic w_unused;
    assign w_unused = ^{aw_prot_i[2:1], ar_prot_i[2:1]};
endmodule

// File: tb/tb_axi_lite_mem_slv.sv
// Directed bench: a PrivOnly=0 DUT and a PrivOnly=1 DUT share all inputs.
module tb_axi_lite_mem_slv;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] aw_addr, ar_addr;
    logic [2:0]  aw_prot, ar_prot;
    logic        aw_valid, w_valid, b_ready, ar_valid, r_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic [1:0]  b_resp, r_resp;
    logic [63:0] r_data;
    logic        p_aw_ready, p_w_ready, p_b_valid, p_ar_ready, p_r_valid;
    logic [1:0]  p_b_resp, p_r_resp;
    logic [63:0] p_r_data;

    axi_lite_mem_slv dut (
        .clk_i(clk), .rst_i(rst),
        .aw_addr_i(aw_addr), .aw_prot_i(aw_prot), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
        .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready),
        .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
        .ar_addr_i(ar_addr), .ar_prot_i(ar_prot), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
        .r_data_o(r_data), .r_resp_o(r_resp), .r_valid_o(r_valid), .r_ready_i(r_ready)
    );

    axi_lite_mem_slv #(.PrivOnly(1'b1)) dut_p (
        .clk_i(clk), .rst_i(rst),
        .aw_addr_i(aw_addr), .aw_prot_i(aw_prot), .aw_valid_i(aw_valid), .aw_ready_o(p_aw_ready),
        .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(p_w_ready),
        .b_resp_o(p_b_resp), .b_valid_o(p_b_valid), .b_ready_i(b_ready),
        .ar_addr_i(ar_addr), .ar_prot_i(ar_prot), .ar_valid_i(ar_valid), .ar_ready_o(p_ar_ready),
        .r_data_o(p_r_data), .r_resp_o(p_r_resp), .r_valid_o(p_r_valid), .r_ready_i(r_ready)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents AW and W together; returns just after the edge completing both handshakes.
    task automatic aw_w_hs(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                           input logic [2:0] p);
        logic awd, wd, a_s, w_s;
        awd = 1'b0; wd = 1'b0;
        aw_addr = a; aw_prot = p; aw_valid = 1'b1;
        w_data = d; w_strb = s; w_valid = 1'b1;
        for (int t = 0; t < 20 && !(awd && wd); t++) begin
            a_s = aw_ready; w_s = w_ready;
            tick();
            if (a_s && aw_valid) begin awd = 1'b1; aw_valid = 1'b0; end
            if (w_s && w_valid)  begin wd  = 1'b1; w_valid  = 1'b0; end
        end
        aw_valid = 1'b0; w_valid = 1'b0;
        chk("aw_hs", awd, 1'b1);
        chk("w_hs", wd, 1'b1);
    endtask

    task automatic wait_b(output logic [1:0] resp, output logic [1:0] presp, output int lat);
        lat = 0;
        while (!b_valid && lat < 20) begin tick(); lat++; end
        chk("b_valid", b_valid, 1'b1);
        resp = b_resp; presp = p_b_resp;
        if (b_ready) tick();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            input logic [2:0] p, output logic [1:0] resp,
                            output logic [1:0] presp, output int lat);
        aw_w_hs(a, d, s, p);
        wait_b(resp, presp, lat);
    endtask

    task automatic ar_hs(input logic [31:0] a, input logic [2:0] p);
        logic done, r_s;
        done = 1'b0;
        ar_addr = a; ar_prot = p; ar_valid = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            r_s = ar_ready;
            tick();
            if (r_s) done = 1'b1;
        end
        ar_valid = 1'b0;
        chk("ar_hs", done, 1'b1);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [2:0] p,
                           output logic [63:0] d, output logic [1:0] resp,
                           output logic [63:0] pd, output logic [1:0] presp);
        ar_hs(a, p);
        chk("r_valid", r_valid, 1'b1);
        d = r_data; resp = r_resp; pd = p_r_data; presp = p_r_resp;
        tick();
    endtask

    logic [63:0] d, pd;
    logic [1:0]  rs, prs;
    int          lat;

    initial begin
        rst = 1'b1; aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
        b_ready = 1'b1; r_ready = 1'b1;
        aw_addr = '0; aw_prot = '0; w_data = '0; w_strb = '0; ar_addr = '0; ar_prot = '0;

        // 1: reset and idle
        repeat (5) tick();
        chk("rst_ctl", {aw_ready, w_ready, ar_ready, b_valid, r_valid, b_resp, r_resp}, 9'h0);
        chk("rst_rdata", r_data, 64'h0);
        rst = 1'b0;
        chk("post_rst_rdy0", {aw_ready, w_ready, ar_ready}, 3'b000);
        tick();
        chk("post_rst_rdy1", {aw_ready, w_ready, ar_ready}, 3'b111);
        do_read(32'h0, 3'b000, d, rs, pd, prs);
        chk("rd0_data", d, 64'h0);
        chk("rd0_resp", rs, 2'b00);

        // 2: same-cycle AW/W then read back
        do_write(32'h10, 64'hDEADBEEF_DEADBEEF, 8'hFF, 3'b000, rs, prs, lat);
        chk("wr10_lat", lat, 1);
        chk("wr10_resp", rs, 2'b00);
        do_read(32'h10, 3'b000, d, rs, pd, prs);
        chk("rd10_data", d, 64'hDEADBEEF_DEADBEEF);

        // 3: W two cycles ahead of AW, low-half strobes
        w_data = 64'h11223344_55667788; w_strb = 8'h0F; w_valid = 1'b1;
        chk("w_early_rdy", w_ready, 1'b1);
        tick();
        w_valid = 1'b0;
        chk("w_held0", w_ready, 1'b0);
        tick();
        chk("w_held1", {w_ready, aw_ready}, 2'b01);
        aw_addr = 32'h10; aw_prot = 3'b000; aw_valid = 1'b1;
        tick();
        aw_valid = 1'b0;
        chk("w3_bv0", b_valid, 1'b0);
        tick();
        chk("w3_b", {b_valid, b_resp}, 3'b100);
        tick();
        do_read(32'h10, 3'b000, d, rs, pd, prs);
        chk("rd10_strb", d, 64'hDEADBEEF_55667788);

        // 4: decode and privilege errors
        do_write(32'h800, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 3'b000, rs, prs, lat);
        chk("wr800_resp", rs, 2'b11);
        do_read(32'h800, 3'b000, d, rs, pd, prs);
        chk("rd800_resp", rs, 2'b11);
        chk("rd800_data", d, 64'h0);
        do_read(32'h0, 3'b000, d, rs, pd, prs);
        chk("rd0_unchanged", d, 64'h0);
        do_write(32'h20, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, 3'b000, rs, prs, lat);
        chk("priv_wr_slv", prs, 2'b10);
        chk("priv_wr_ok0", rs, 2'b00);
        do_read(32'h20, 3'b001, d, rs, pd, prs);
        chk("priv_rd_ok", prs, 2'b00);
        chk("priv_mem_kept", pd, 64'h0);
        do_write(32'h20, 64'h0123_4567_89AB_CDEF, 8'hFF, 3'b001, rs, prs, lat);
        chk("priv_wr_ok", prs, 2'b00);
        do_read(32'h20, 3'b000, d, rs, pd, prs);
        chk("priv_rd_slv", {prs, pd}, {2'b10, 64'h0});
        do_read(32'h20, 3'b001, d, rs, pd, prs);
        chk("priv_rd_data", pd, 64'h0123_4567_89AB_CDEF);

        // 5: backpressure on B and R
        b_ready = 1'b0;
        aw_w_hs(32'h800, 64'h0, 8'hFF, 3'b000);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("b_stall", {b_valid, b_resp, aw_ready, w_ready}, 5'b11100);
            tick();
        end
        b_ready = 1'b1;
        tick();
        chk("b_release", b_valid, 1'b0);
        r_ready = 1'b0;
        ar_hs(32'h10, 3'b000);
        for (int i = 0; i < 10; i++) begin
            chk("r_stall", {r_valid, ar_ready, r_resp}, 4'b1000);
            chk("r_stall_data", r_data, 64'hDEADBEEF_55667788);
            tick();
        end
        r_ready = 1'b1;
        tick();
        chk("r_release", r_valid, 1'b0);

        // 6: read/write collision, then reset mid-response
        do_write(32'h18, 64'h0123_4567_89AB_CDEF, 8'hFF, 3'b000, rs, prs, lat);
        aw_w_hs(32'h18, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 3'b000);
        ar_addr = 32'h18; ar_prot = 3'b000; ar_valid = 1'b1;
        chk("coll_ar_rdy", ar_ready, 1'b1);
        tick();
        ar_valid = 1'b0;
        chk("coll_vld", {b_valid, r_valid}, 2'b11);
        chk("coll_old", r_data, 64'h0123_4567_89AB_CDEF);
        tick();
        do_read(32'h18, 3'b000, d, rs, pd, prs);
        chk("coll_new", d, 64'hA5A5_A5A5_A5A5_A5A5);

        b_ready = 1'b0;
        aw_w_hs(32'h30, 64'h5555_6666_7777_8888, 8'hFF, 3'b000);
        tick();
        chk("mid_bv", b_valid, 1'b1);
        rst = 1'b1;
        tick();
        chk("mid_rst_bv", {b_valid, r_valid}, 2'b00);
        rst = 1'b0; b_ready = 1'b1;
        tick();
        do_read(32'h18, 3'b000, d, rs, pd, prs);
        chk("rst_mem18", d, 64'h0);
        do_read(32'h10, 3'b000, d, rs, pd, prs);
        chk("rst_mem10", d, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
